clint_ctrl: RTL and testbench
=============================

# clint_ctrl

Core-local trap sequencer: the initiator side of the CSR register file's CLINT write/read port. On an `ecall`, `ebreak` or timer interrupt it freezes the pipeline and writes `mepc`, `mcause` and `mstatus` one per cycle. It then redirects fetch to `mtvec`. On `mret` it restores `mstatus` and redirects fetch to `mepc`. It sits between ID/EX (event sources), the CSR register file (CLINT port) and the PC/hold logic.

## Interface
- No parameters. All data and address buses are 32 bits. CSR addresses occupy bits [11:0]; bits [31:12] are 0.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- inst_addr_i  in  32  PC of the instruction currently in EX
- ecall_i / ebreak_i / mret_i  in  1 each  decoded EX instruction is ecall / ebreak / mret
- jump_flag_i  in  1  EX is redirecting the PC this cycle
- jump_addr_i  in  32  redirect target
- irq_timer_i  in  1  timer interrupt request, level
- global_int_en_i  in  1  `mstatus.MIE` from the CSR file
- csr_mtvec_i / csr_mepc_i / csr_mstatus_i  in  32 each  live CSR values
- wb_csr_we_i  in  1  WB is writing a CSR this cycle; the WB write has priority in the CSR file
- csr_we_o  out  1  CLINT CSR write enable
- csr_waddr_o  out  32  CLINT CSR write address
- csr_wdata_o  out  32  CLINT CSR write data
- hold_o  out  1  stall the whole pipeline
- int_assert_o  out  1  one-cycle PC redirect strobe
- int_addr_o  out  32  redirect target

## Operation
- States:
  - IDLE
  - W_MEPC
  - W_MCAUSE
  - W_MSTATUS
  - ASSERT
- Event priority in IDLE, one event accepted per visit:
  - ecall / ebreak first
  - then mret
  - then the timer interrupt, only when `irq_timer_i && global_int_en_i`, and only when the `CLINT_TIMER_IRQ_EN` macro is defined
- Trap path: IDLE → W_MEPC → W_MCAUSE → W_MSTATUS → ASSERT → IDLE.
- mret path: IDLE → W_MSTATUS → ASSERT → IDLE.
- Values latched on acceptance:
  - Event type.
  - Saved PC = `jump_addr_i` if `jump_flag_i`, else `inst_addr_i`. For an interrupt this is the first instruction not executed.
  - Cause: ecall = 32'd11, ebreak = 32'd3, timer = 32'h8000_0007.
- Writes (Moore, decoded from state):
  - W_MEPC: address 0x341, data = saved PC.
  - W_MCAUSE: address 0x342, data = cause.
  - W_MSTATUS (trap): address 0x300; MPIE[7] ← MIE[3], MIE[3] ← 0, other bits from `csr_mstatus_i`.
  - W_MSTATUS (mret): address 0x300; MIE[3] ← MPIE[7], MPIE[7] ← 1, other bits unchanged.
- ASSERT: `int_assert_o` = 1. `int_addr_o` = `csr_mtvec_i` for a trap, `csr_mepc_i` for mret, both sampled that cycle. No CSR write in ASSERT.
- WB collision: in any W_* state with `wb_csr_we_i` = 1, the FSM stays in the same state and re-presents the identical write next cycle, so no CLINT write is lost.
- `hold_o`:
  - combinationally 1 in the IDLE cycle an event is accepted;
  - 1 in every non-IDLE state, including ASSERT;
  - 0 otherwise.
- Events arriving while not IDLE are ignored. The held pipeline keeps them stable.

## Timing
- Reset values: state IDLE; `csr_we_o` = 0, `csr_waddr_o` = 0, `csr_wdata_o` = 0, `hold_o` = 0, `int_assert_o` = 0, `int_addr_o` = 0; latches cleared.
- Trap accepted at cycle T: writes at T+1, T+2, T+3; `int_assert_o` at T+4; IDLE at T+5. Each cycle of WB collision adds 1 cycle.
- mret accepted at T: `mstatus` write at T+1; `int_assert_o` at T+2; IDLE at T+3.
- An event present in the IDLE cycle right after ASSERT is accepted normally (back-to-back traps are allowed).
- `rst_n` = 0 mid-sequence: IDLE and all outputs 0 from the next edge. Partial CSR writes already made are not undone.
- `int_addr_o` is 0 whenever `int_assert_o` = 0.

## Configuration
- `CLINT_TIMER_IRQ_EN` defined: the timer interrupt path is active, with cause 32'h8000_0007.
- `CLINT_TIMER_IRQ_EN` undefined: `irq_timer_i` and `global_int_en_i` are ignored. Only ecall, ebreak and mret are sequenced.

## Test plan
- ecall at `inst_addr_i` = 0x8000_0010, `mstatus` = 0x8, `mtvec` = 0x8000_0100 → writes (0x341, 0x8000_0010), (0x342, 11), (0x300, 0x80) on T+1..T+3; T+4 `int_assert_o` = 1, `int_addr_o` = 0x8000_0100; `hold_o` high T..T+4.
- mret with `mstatus` = 0x80, `mepc` = 0x8000_0014 → T+1 write (0x300, 0x88); T+2 `int_addr_o` = 0x8000_0014.
- Timer irq with MIE = 1 while `jump_flag_i` = 1, `jump_addr_i` = 0x8000_0200 → `mepc` write data 0x8000_0200, `mcause` 0x8000_0007. Repeat with MIE = 0 → no response. Macro undefined → no response.
- ecall and irq simultaneously → `mcause` = 11. `wb_csr_we_i` high for 2 cycles during W_MCAUSE → the W_MCAUSE write is held 3 cycles and `int_assert_o` is delayed by 2.
- Reset asserted at T+2 of a trap → outputs 0 at T+3; a later ecall runs the full sequence from IDLE.

Source files
------------

// File: rtl/clint_ctrl.sv
// rtl/clint_ctrl.sv - CLINT trap sequencer: saves mepc/mcause/mstatus and redirects fetch (timer path: CLINT_TIMER_IRQ_EN)
module clint_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        irq_timer_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic        wb_csr_we_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_ASSERT
    } state_t;

    localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;

    state_t      state_q, state_d;
    logic        is_mret_q, is_mret_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic [31:0] cause_q, cause_d;
    logic        irq_evt;
    logic [31:0] pc_sel;

`ifdef CLINT_TIMER_IRQ_EN
    assign irq_evt = irq_timer_i & global_int_en_i;
`else
    logic unused_irq;
    assign unused_irq = irq_timer_i ^ global_int_en_i;
    assign irq_evt    = 1'b0;
`endif

    // A pending redirect means the instruction at inst_addr_i will not be the next one executed.
    assign pc_sel = jump_flag_i ? jump_addr_i : inst_addr_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_mret_q  <= 1'b0;
            saved_pc_q <= 32'h0;
            cause_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_mret_q  <= is_mret_d;
            saved_pc_q <= saved_pc_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_mret_d    = is_mret_q;
        saved_pc_d   = saved_pc_q;
        cause_d      = cause_q;
        csr_we_o     = 1'b0;
        csr_waddr_o  = 32'h0;
        csr_wdata_o  = 32'h0;
        hold_o       = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (rst_n) begin
                    if (ecall_i || ebreak_i) begin
                        state_d    = S_W_MEPC;
                        is_mret_d  = 1'b0;
                        saved_pc_d = pc_sel;
                        cause_d    = ecall_i ? 32'd11 : 32'd3;
                        hold_o     = 1'b1;
                    end else if (mret_i) begin
                        state_d   = S_W_MSTATUS;
                        is_mret_d = 1'b1;
                        hold_o    = 1'b1;
                    end else if (irq_evt) begin
                        state_d    = S_W_MEPC;
                        is_mret_d  = 1'b0;
                        saved_pc_d = pc_sel;
                        cause_d    = 32'h8000_0007;
                        hold_o     = 1'b1;
                    end
                end
            end
            S_W_MEPC: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = saved_pc_q;
                if (!wb_csr_we_i) state_d = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
                if (!wb_csr_we_i) state_d = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = csr_mstatus_i;
                if (is_mret_q) begin
                    csr_wdata_o[3] = csr_mstatus_i[7];
                    csr_wdata_o[7] = 1'b1;
                end else begin
                    csr_wdata_o[7] = csr_mstatus_i[3];
                    csr_wdata_o[3] = 1'b0;
                end
                if (!wb_csr_we_i) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                hold_o       = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = is_mret_q ? csr_mepc_i : csr_mtvec_i;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// tb/tb_clint_ctrl.sv - scoreboard bench for clint_ctrl with directed trap/mret vectors
module tb_clint_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr_i;
    logic        ecall_i, ebreak_i, mret_i, jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        irq_timer_i, global_int_en_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        wb_csr_we_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o, csr_wdata_o;
    logic        hold_o, int_assert_o;
    logic [31:0] int_addr_o;

    clint_ctrl dut (
        .clk(clk), .rst_n(rst_n), .inst_addr_i(inst_addr_i),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .irq_timer_i(irq_timer_i), .global_int_en_i(global_int_en_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .wb_csr_we_i(wb_csr_we_i), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .hold_o(hold_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_assert;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input bit is_a, input logic [31:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.is_assert = is_a; e.addr = a; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented write or redirect is matched against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 || csr_we_o || int_assert_o) begin
            if (csr_we_o || int_assert_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {31'h0, int_assert_o, csr_waddr_o, csr_wdata_o}, 96'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("output_value",
                          {31'h0, int_assert_o, int_assert_o ? 32'h0 : csr_waddr_o,
                           int_assert_o ? int_addr_o : csr_wdata_o},
                          {31'h0, e.is_assert, e.addr, e.data});
                    check("output_cycle", 96'(cyc), 96'(e.cyc));
                end
            end
            if (!int_assert_o) check("int_addr_zero", {64'h0, int_addr_o}, 96'h0);
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("hold_idle", 96'(hold_o), 96'h0);
            @(posedge clk); #1;
        end
    endtask

    // Entry/exit at posedge+1; the event is presented in the entry cycle T.
    task automatic run_trap(input int ev, input bit also_irq, input logic [31:0] pc, input bit jf,
                            input logic [31:0] jaddr, input logic [31:0] ms, input logic [31:0] mtvec,
                            input logic [31:0] exp_mepc, input logic [31:0] exp_cause,
                            input logic [31:0] exp_ms, input int wb_len);
        int t;
        int total;
        t = cyc;
        total = 5 + wb_len;
        inst_addr_i = pc; jump_flag_i = jf; jump_addr_i = jaddr;
        csr_mstatus_i = ms; csr_mtvec_i = mtvec;
        ecall_i = (ev == 0); ebreak_i = (ev == 1);
        irq_timer_i = (ev == 2) || also_irq; global_int_en_i = (ev == 2) || also_irq;
        push(0, 32'h341, exp_mepc, t + 1);
        for (int i = 0; i <= wb_len; i++) push(0, 32'h342, exp_cause, t + 2 + i);
        push(0, 32'h300, exp_ms, t + 3 + wb_len);
        push(1, 32'h0, mtvec, t + 4 + wb_len);
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            check("hold_trap", 96'(hold_o), 96'h1);
            @(posedge clk); #1;
            if (k == 0) begin
                ecall_i = 0; ebreak_i = 0; irq_timer_i = 0; global_int_en_i = 0; jump_flag_i = 0;
            end
            wb_csr_we_i = (wb_len > 0) && (k + 1 >= 2) && (k + 1 < 2 + wb_len);
        end
        wb_csr_we_i = 0;
    endtask

    task automatic run_mret(input logic [31:0] ms, input logic [31:0] mepc, input logic [31:0] exp_ms);
        int t;
        t = cyc;
        csr_mstatus_i = ms; csr_mepc_i = mepc; mret_i = 1;
        push(0, 32'h300, exp_ms, t + 1);
        push(1, 32'h0, mepc, t + 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_mret", 96'(hold_o), 96'h1);
            @(posedge clk); #1;
            mret_i = 0;
        end
    endtask

    initial begin
        rst_n = 0; inst_addr_i = 0; ecall_i = 0; ebreak_i = 0; mret_i = 0;
        jump_flag_i = 0; jump_addr_i = 0; irq_timer_i = 0; global_int_en_i = 0;
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0; wb_csr_we_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {csr_we_o, hold_o, int_assert_o, csr_waddr_o[28:0], csr_wdata_o, int_addr_o}, 96'h0);
        @(posedge clk); #1;
        rst_n = 1;
        idle(2);

        run_trap(0, 0, 32'h8000_0010, 0, 32'h0, 32'h0000_0008, 32'h8000_0100,
                 32'h8000_0010, 32'd11, 32'h0000_0080, 0);
        idle(1);
        run_mret(32'h0000_0080, 32'h8000_0014, 32'h0000_0088);
        idle(1);
        run_trap(1, 0, 32'h8000_0040, 1, 32'h8000_0200, 32'h0000_0088, 32'h8000_0180,
                 32'h8000_0200, 32'd3, 32'h0000_0080, 0);
        idle(1);
        run_trap(0, 1, 32'h8000_0050, 0, 32'h0, 32'h0000_1888, 32'h8000_0100,
                 32'h8000_0050, 32'd11, 32'h0000_1880, 2);
        idle(1);

`ifdef CLINT_TIMER_IRQ_EN
        run_trap(2, 0, 32'h8000_0060, 1, 32'h8000_0200, 32'h0000_0008, 32'h8000_0100,
                 32'h8000_0200, 32'h8000_0007, 32'h0000_0080, 0);
        idle(1);
        irq_timer_i = 1; global_int_en_i = 0;
        idle(4);
        irq_timer_i = 0;
`else
        irq_timer_i = 1; global_int_en_i = 1;
        idle(4);
        irq_timer_i = 0; global_int_en_i = 0;
`endif
        idle(1);

        // mret immediately followed by ecall in the IDLE cycle after ASSERT
        run_mret(32'h0000_0000, 32'h8000_0300, 32'h0000_0080);
        run_trap(0, 0, 32'h8000_0070, 0, 32'h0, 32'h0000_0008, 32'h8000_0400,
                 32'h8000_0070, 32'd11, 32'h0000_0080, 0);
        idle(1);

        begin : reset_mid
            int t;
            t = cyc;
            inst_addr_i = 32'h8000_0090; csr_mstatus_i = 32'h8; ecall_i = 1;
            push(0, 32'h341, 32'h8000_0090, t + 1);
            push(0, 32'h342, 32'd11, t + 2);
            @(negedge clk); check("hold_rst_t0", 96'(hold_o), 96'h1);
            @(posedge clk); #1; ecall_i = 0;
            @(negedge clk); check("hold_rst_t1", 96'(hold_o), 96'h1);
            @(posedge clk); #1; rst_n = 0;
            @(posedge clk); #1;
            @(negedge clk);
            check("reset_mid_outputs", {csr_we_o, hold_o, int_assert_o, csr_waddr_o[28:0], csr_wdata_o, int_addr_o}, 96'h0);
            @(posedge clk); #1; rst_n = 1;
        end
        idle(1);
        run_trap(0, 0, 32'h8000_00a0, 0, 32'h0, 32'h0000_0008, 32'h8000_0100,
                 32'h8000_00a0, 32'd11, 32'h0000_0080, 0);
        idle(3);
        check("queue_drained", 96'(exp_q.size()), 96'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
